fifo_write_arbiter: RTL and testbench

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_write_arbiter_pkg.sv | 29 ++
 rtl/fifo_rr_pick.sv | 36 +++
 rtl/fifo_write_arbiter.sv | 164 ++++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter_pkg
// Shared types and helpers for the multi-producer FIFO write arbiter.
//   arb_state_t    : arbiter FSM encoding (IDLE = nobody granted, GRANT = one-hot)
//   onehot_to_idx  : converts a one-hot port vector (up to MAX_PORTS) to an index
// ---------------------------------------------------------------------------
package fifo_write_arbiter_pkg;

    localparam int unsigned MAX_PORTS = 16;
    localparam int unsigned MAX_IDX_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Index of the set bit of a one-hot vector; zero when the vector is empty.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_PORTS-1:0] onehot);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_PORTS; i++) begin
            if (onehot[i]) begin
                idx = MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// ---------------------------------------------------------------------------
// fifo_rr_pick
// Combinational round-robin picker. Searches the request vector starting at
// (i_ptr + 1) mod NUM_PORTS and returns the first requester as a one-hot grant.
//   i_req       : per-port request vector
//   i_ptr       : index of the port granted last
//   o_gnt_c     : one-hot grant (all zero when nobody requests)
//   o_valid_c   : high when o_gnt_c has a bit set
// ---------------------------------------------------------------------------
module fifo_rr_pick #(
    parameter int unsigned NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0]         i_req,
    input  logic [$clog2(NUM_PORTS)-1:0] i_ptr,
    output logic [NUM_PORTS-1:0]         o_gnt_c,
    output logic                         o_valid_c
);

    localparam int unsigned PTR_W = $clog2(NUM_PORTS);

    // The last-granted port is visited last, so it only wins when alone.
    always_comb begin
        logic [PTR_W-1:0] w_idx;
        o_gnt_c   = '0;
        o_valid_c = 1'b0;
        w_idx     = '0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            w_idx = PTR_W'((32'(i_ptr) + k) % NUM_PORTS);
            if (!o_valid_c && i_req[w_idx]) begin
                o_gnt_c[w_idx] = 1'b1;
                o_valid_c      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter
// Merges NUM_PORTS producer write ports into one downstream FIFO write port.
// A registered one-hot grant selects one producer at a time; a port keeps the
// grant for up to MAX_BURST words, then the next requester round-robin wins.
// A single-word output register decouples the downstream full flag.
//   clk, reset     : rising-edge clock, asynchronous active-high reset
//   in_full_n      : per-port ready (granted port and output space available)
//   in_write       : per-port write strobe / request
//   in_din         : per-port data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_full_n     : downstream not-full
//   out_write      : downstream write strobe
//   out_write_ce   : downstream write clock enable (always 1)
//   out_din        : downstream write data
// ---------------------------------------------------------------------------
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    output logic [NUM_PORTS-1:0]            in_full_n,
    input  logic [NUM_PORTS-1:0]            in_write,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_din,
    input  logic                            out_full_n,
    output logic                            out_write,
    output logic                            out_write_ce,
    output logic [DATA_WIDTH-1:0]           out_din
);

    localparam int unsigned PTR_W = $clog2(NUM_PORTS);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    // Elaboration-time parameter range checks.
    if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS) begin : g_bad_num_ports
        $error("fifo_write_arbiter: NUM_PORTS must be 2..16");
    end
    if (MAX_BURST < 1 || MAX_BURST > 256) begin : g_bad_max_burst
        $error("fifo_write_arbiter: MAX_BURST must be 1..256");
    end

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [NUM_PORTS-1:0]   r_grant;
    logic [NUM_PORTS-1:0]   w_grant_nxt;
    logic [PTR_W-1:0]       r_last;
    logic [PTR_W-1:0]       w_last_nxt;
    logic [CNT_W-1:0]       r_burst;
    logic [CNT_W-1:0]       w_burst_nxt;
    logic [CNT_W-1:0]       w_burst_inc;

    logic                   r_out_write;
    logic [DATA_WIDTH-1:0]  r_out_din;

    logic                   w_space;
    logic                   w_gnt_req;
    logic                   w_xfer;
    logic                   w_burst_end;
    logic                   w_rearb;
    logic [NUM_PORTS-1:0]   w_pick_gnt;
    logic                   w_pick_valid;
    logic [DATA_WIDTH-1:0]  w_sel_din;

    // Output register can take a word when empty or when its word drains now.
    assign w_space     = !r_out_write || out_full_n;
    assign w_gnt_req   = |(r_grant & in_write);
    assign w_xfer      = w_gnt_req && w_space;
    assign w_burst_inc = r_burst + CNT_W'(1);
    assign w_burst_end = w_xfer && (w_burst_inc == CNT_W'(MAX_BURST));

    // Round-robin search over the live request vector, starting after r_last.
    fifo_rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_pick (
        .i_req     (in_write),
        .i_ptr     (r_last),
        .o_gnt_c   (w_pick_gnt),
        .o_valid_c (w_pick_valid)
    );

    // Arbiter state register: FSM state, grant, last-granted pointer, burst count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= PTR_W'(NUM_PORTS - 1);
            r_burst <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            r_burst <= w_burst_nxt;
        end
    end

    // Next-state logic. Stall cycles keep the grant and the count untouched
    // as long as the granted port keeps requesting.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_burst_nxt = r_burst;
        w_rearb     = 1'b0;

        case (r_state)
            ST_IDLE:  w_rearb = 1'b1;
            ST_GRANT: w_rearb = !w_gnt_req || w_burst_end;
        endcase

        if (w_xfer) begin
            w_burst_nxt = w_burst_inc;
        end

        if (w_rearb) begin
            w_burst_nxt = '0;
            w_grant_nxt = w_pick_gnt;
            if (w_pick_valid) begin
                w_state_nxt = ST_GRANT;
                w_last_nxt  = PTR_W'(onehot_to_idx(MAX_PORTS'(w_pick_gnt)));
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    // Output logic: ready only from the registered grant, never from in_write.
    always_comb begin
        in_full_n    = '0;
        out_write_ce = 1'b1;
        if (r_state == ST_GRANT && w_space) begin
            in_full_n = r_grant;
        end
    end

    // Data select from the granted port (one-hot AND-OR mux).
    always_comb begin
        w_sel_din = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (r_grant[i]) begin
                w_sel_din = w_sel_din | in_din[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // One-word output stage; the word is held while downstream is full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_write <= 1'b0;
            r_out_din   <= '0;
        end else if (w_xfer) begin
            r_out_write <= 1'b1;
            r_out_din   <= w_sel_din;
        end else if (out_full_n) begin
            r_out_write <= 1'b0;
        end
    end

    assign out_write = r_out_write;
    assign out_din   = r_out_din;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_write_arbiter
// Directed scenarios followed by a randomized run. A behavioural model
// predicts ready/valid each cycle and pushes accepted words into a scoreboard;
// a separate monitor pops and compares whenever downstream accepts a word.
// ---------------------------------------------------------------------------
module tb_fifo_write_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int MB = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NP-1:0]     in_full_n;
    logic [NP-1:0]     in_write;
    logic [NP*DW-1:0]  in_din;
    logic              out_full_n;
    logic              out_write;
    logic              out_write_ce;
    logic [DW-1:0]     out_din;

    int n_err = 0;
    int n_chk = 0;

    logic [DW-1:0] gen_q [NP][$];
    logic [DW-1:0] sb_q [$];
    int            xfer_log [$];
    int            seq [NP];

    // Reference model: owner (-1 = nobody), last granted, words in burst,
    // and contents of the one-word output stage.
    int            m_owner;
    int            m_last;
    int            m_cnt;
    bit            m_ov;
    logic [DW-1:0] m_od;

    fifo_write_arbiter #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_full_n    (in_full_n),
        .in_write     (in_write),
        .in_din       (in_din),
        .out_full_n   (out_full_n),
        .out_write    (out_write),
        .out_write_ce (out_write_ce),
        .out_din      (out_din)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = NP - 1;
        m_cnt   = 0;
        m_ov    = 1'b0;
        m_od    = '0;
        sb_q.delete();
    endtask

    // One clock cycle: drive at negedge, check against the model, advance model.
    task automatic cycle(input logic [NP-1:0] want, input bit ofn);
        logic [NP-1:0] w;
        logic [NP-1:0] exp_ifn;
        bit            space;
        bit            xfer;
        bit            rearb;
        int            nxt;
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            w[p] = want[p] && (gen_q[p].size() > 0);
            in_din[p*DW +: DW] = (gen_q[p].size() > 0) ? gen_q[p][0] : '0;
        end
        in_write   = w;
        out_full_n = ofn;
        #1;
        space   = !m_ov || ofn;
        exp_ifn = '0;
        if (m_owner >= 0 && space) exp_ifn[m_owner] = 1'b1;
        chk("in_full_n", 32'(in_full_n), 32'(exp_ifn));
        chk("out_write", 32'(out_write), 32'(m_ov));
        if (m_ov) chk("out_din_held", out_din, m_od);

        xfer = (m_owner >= 0) && w[m_owner] && space;
        if (xfer) sb_q.push_back(gen_q[m_owner][0]);

        // Producers pop on the handshake they actually see.
        for (int p = 0; p < NP; p++) begin
            if (w[p] && in_full_n[p]) begin
                xfer_log.push_back(p);
                void'(gen_q[p].pop_front());
            end
        end

        rearb = (m_owner < 0) || !w[m_owner] || (xfer && (m_cnt + 1 == MB));
        if (xfer) begin
            m_od = sb_q[sb_q.size()-1];
            m_ov = 1'b1;
            m_cnt++;
        end else if (ofn) begin
            m_ov = 1'b0;
        end
        if (rearb) begin
            nxt = -1;
            for (int k = 1; k <= NP; k++) begin
                int c;
                c = (m_last + k) % NP;
                if (nxt < 0 && w[c]) nxt = c;
            end
            m_cnt   = 0;
            m_owner = nxt;
            if (nxt >= 0) m_last = nxt;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_write = '0;
        reset    = 1'b1;
        for (int p = 0; p < NP; p++) gen_q[p].delete();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Scoreboard monitor: every downstream acceptance must match the oldest word.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset && out_write && out_full_n) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL sb_underflow: out_din 0x%0h with nothing expected at %0t", out_din, $time);
                end else begin
                    chk("sb_out_din", out_din, sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        int exp_order [12];
        in_write   = '0;
        in_din     = '0;
        out_full_n = 1'b1;
        reset      = 1'b1;
        for (int p = 0; p < NP; p++) seq[p] = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_write", 32'(out_write), 32'd0);
        chk("rst_in_full_n", 32'(in_full_n), 32'd0);
        chk("rst_out_din", out_din, 32'd0);
        chk("out_write_ce", 32'(out_write_ce), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Single port, back-to-back words.
        for (int k = 0; k < 4; k++) gen_q[2].push_back(32'h10 + 32'(k));
        for (int i = 0; i < 7; i++) begin
            cycle(4'b0100, 1'b1);
            if (i >= 2 && i <= 5) begin
                chk("single_out_write", 32'(out_write), 32'd1);
                chk("single_out_din", out_din, 32'h10 + 32'(i - 2));
            end
        end
        repeat (2) cycle(4'b0000, 1'b1);

        // Fairness with bursts of MB words.
        do_reset();
        for (int p = 0; p < NP; p++)
            if (p != 2) for (int k = 0; k < 8; k++) gen_q[p].push_back((32'(p) << 24) | 32'(k));
        xfer_log.delete();
        repeat (14) cycle(4'b1011, 1'b1);
        exp_order = '{0, 0, 1, 1, 3, 3, 0, 0, 1, 1, 3, 3};
        chk("fair_count_ok", 32'(xfer_log.size() >= 12), 32'd1);
        for (int i = 0; i < 12 && i < xfer_log.size(); i++)
            chk("fair_order", 32'(xfer_log[i]), 32'(exp_order[i]));
        for (int p = 0; p < NP; p++) gen_q[p].delete();
        repeat (3) cycle(4'b0000, 1'b1);

        // Backpressure mid-burst.
        for (int k = 0; k < 8; k++) gen_q[1].push_back(32'h1100_0000 | 32'(k));
        for (int i = 0; i < 20; i++) begin
            cycle(4'b0010, !(i >= 4 && i < 9));
            if (i >= 5 && i < 9) chk("bp_in_full_n", 32'(in_full_n), 32'd0);
        end
        chk("bp_all_sent", 32'(gen_q[1].size()), 32'd0);
        repeat (2) cycle(4'b0000, 1'b1);

        // Granted port drops its request; search wraps to port 0.
        for (int k = 0; k < 3; k++) gen_q[1].push_back(32'h2100_0000 | 32'(k));
        for (int i = 0; i < 10 && gen_q[1].size() > 0; i++) cycle(4'b0010, 1'b1);
        chk("drop_p1_sent", 32'(gen_q[1].size()), 32'd0);
        gen_q[0].push_back(32'h2000_0000);
        gen_q[0].push_back(32'h2000_0001);
        cycle(4'b0011, 1'b1);
        cycle(4'b0001, 1'b1);
        chk("drop_switch_p0", 32'(in_full_n), 32'b0001);
        cycle(4'b0001, 1'b1);
        repeat (3) cycle(4'b0000, 1'b1);
        chk("drop_p0_sent", 32'(gen_q[0].size()), 32'd0);

        // Reset while a word sits in the output stage.
        gen_q[3].push_back(32'hAB);
        repeat (3) cycle(4'b1000, 1'b0);
        chk("pre_rst_out_write", 32'(out_write), 32'd1);
        chk("pre_rst_out_din", out_din, 32'hAB);
        @(posedge clk);
        #2;
        reset    = 1'b1;
        in_write = '0;
        #1;
        chk("mid_rst_out_write", 32'(out_write), 32'd0);
        chk("mid_rst_in_full_n", 32'(in_full_n), 32'd0);
        chk("mid_rst_out_din", out_din, 32'd0);
        model_reset();
        for (int p = 0; p < NP; p++) gen_q[p].delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        gen_q[0].push_back(32'h3000_0000);
        gen_q[3].push_back(32'h3300_0000);
        xfer_log.delete();
        repeat (4) cycle(4'b1001, 1'b1);
        chk("post_rst_first_port", 32'(xfer_log.size() > 0 ? xfer_log[0] : -1), 32'd0);
        repeat (3) cycle(4'b0000, 1'b1);

        // Random requests and downstream backpressure.
        for (int p = 0; p < NP; p++) seq[p] = 0;
        for (int i = 0; i < 10000; i++) begin
            for (int p = 0; p < NP; p++) begin
                if (gen_q[p].size() < 4) begin
                    gen_q[p].push_back(32'h4000_0000 | (32'(p) << 24) | 32'(seq[p]));
                    seq[p]++;
                end
            end
            cycle(NP'($urandom), ($urandom % 4) != 0);
        end
        repeat (6) cycle(4'b0000, 1'b1);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
